// File: rtl/feature_addr_gen.sv
// feature_addr_gen: feature address sequencer for the weight ROM readers.
// Takes one (start, len) stage descriptor and issues start..start+len-1,
// broadcasting each address to three valid/ready ports through an eager fork.
// Optional macro FEATURE_ADDR_LAST_EN adds per-port addrN_last flags that mark
// the final address of a stage.
module feature_addr_gen #(
  parameter int unsigned W_ADDR = 12,
  parameter int unsigned W_LEN  = 8,
  parameter int unsigned N_OUT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stage_valid,
  output logic              stage_ready,
  input  logic [W_ADDR-1:0] stage_start,
  input  logic [W_LEN-1:0]  stage_len,
  output logic              addr0_valid,
  input  logic              addr0_ready,
  output logic [W_ADDR-1:0] addr0_data,
  output logic              addr1_valid,
  input  logic              addr1_ready,
  output logic [W_ADDR-1:0] addr1_data,
  output logic              addr2_valid,
  input  logic              addr2_ready,
  output logic [W_ADDR-1:0] addr2_data,
`ifdef FEATURE_ADDR_LAST_EN
  output logic              addr0_last,
  output logic              addr1_last,
  output logic              addr2_last,
`endif
  output logic              busy
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [W_ADDR-1:0] cur_q, cur_d;
  logic [W_LEN-1:0]  remaining_q, remaining_d;
  logic [N_OUT-1:0]  sent_q, sent_d;

  logic              run;
  logic              beat_done;
  logic              last_beat;
  logic [N_OUT-1:0]  ready_vec;
  logic [N_OUT-1:0]  valid_vec;
  logic [N_OUT-1:0]  hs_vec;
  logic [W_ADDR-1:0] data_out;

  // Fork handshake decode: a port is offered the address until it has taken it.
  always_comb begin
    run         = (state_q == StRun) & ~rst;
    ready_vec   = {addr2_ready, addr1_ready, addr0_ready};
    valid_vec   = {N_OUT{run}} & ~sent_q;
    hs_vec      = valid_vec & ready_vec;
    // Beat is complete once every port has either taken it earlier or takes it now.
    beat_done   = run & (&(sent_q | hs_vec));
    last_beat   = (remaining_q == W_LEN'(1));
    stage_ready = (state_q == StIdle) & ~rst;
    busy        = run;
    data_out    = rst ? '0 : cur_q;
  end

  // Output fan-out to the three ROM reader ports.
  always_comb begin
    addr0_valid = valid_vec[0];
    addr1_valid = valid_vec[1];
    addr2_valid = valid_vec[2];
    addr0_data  = data_out;
    addr1_data  = data_out;
    addr2_data  = data_out;
`ifdef FEATURE_ADDR_LAST_EN
    addr0_last  = valid_vec[0] & last_beat;
    addr1_last  = valid_vec[1] & last_beat;
    addr2_last  = valid_vec[2] & last_beat;
`endif
  end

  // Next-state logic for the sequencer FSM, address counter and fork tracking.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    remaining_d = remaining_q;
    sent_d      = sent_q;
    case (state_q)
      StIdle: begin
        // Zero-length descriptors are consumed without leaving IDLE.
        if (stage_valid && stage_ready && (stage_len != '0)) begin
          cur_d       = stage_start;
          remaining_d = stage_len;
          sent_d      = '0;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (beat_done) begin
          sent_d      = '0;
          cur_d       = cur_q + W_ADDR'(1);
          remaining_d = remaining_q - W_LEN'(1);
          if (last_beat) begin
            state_d = StIdle;
          end
        end else begin
          sent_d = sent_q | hs_vec;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      remaining_q <= '0;
      sent_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      remaining_q <= remaining_d;
      sent_q      <= sent_d;
    end
  end

endmodule

// File: tb/tb_feature_addr_gen.sv
// Directed and randomized bench for feature_addr_gen.
// Honours FEATURE_ADDR_LAST_EN to check the optional addrN_last outputs.
module tb_feature_addr_gen;

  localparam int unsigned AW = 12;
  localparam int unsigned LW = 8;

  logic          clk;
  logic          rst;
  logic          stage_valid;
  logic          stage_ready;
  logic [AW-1:0] stage_start;
  logic [LW-1:0] stage_len;
  logic [2:0]    rdy;
  logic          addr0_valid, addr1_valid, addr2_valid;
  logic [AW-1:0] addr0_data, addr1_data, addr2_data;
  logic          busy;
  logic [2:0]    vld;
  logic [3*AW-1:0] dat;
  logic [2:0]    lst;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] q0[$];
  logic [AW-1:0] q1[$];
  logic [AW-1:0] q2[$];
  logic [AW-1:0] exp_q[$];

`ifdef FEATURE_ADDR_LAST_EN
  logic addr0_last, addr1_last, addr2_last;
  assign lst = {addr2_last, addr1_last, addr0_last};
`else
  assign lst = 3'b000;
`endif

  assign vld = {addr2_valid, addr1_valid, addr0_valid};
  assign dat = {addr2_data, addr1_data, addr0_data};

  feature_addr_gen #(
    .W_ADDR(AW),
    .W_LEN (LW),
    .N_OUT (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stage_valid(stage_valid),
    .stage_ready(stage_ready),
    .stage_start(stage_start),
    .stage_len  (stage_len),
    .addr0_valid(addr0_valid),
    .addr0_ready(rdy[0]),
    .addr0_data (addr0_data),
    .addr1_valid(addr1_valid),
    .addr1_ready(rdy[1]),
    .addr1_data (addr1_data),
    .addr2_valid(addr2_valid),
    .addr2_ready(rdy[2]),
    .addr2_data (addr2_data),
`ifdef FEATURE_ADDR_LAST_EN
    .addr0_last (addr0_last),
    .addr1_last (addr1_last),
    .addr2_last (addr2_last),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted address per port, mid-cycle when all signals are stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (addr0_valid && rdy[0]) q0.push_back(addr0_data);
      if (addr1_valid && rdy[1]) q1.push_back(addr1_data);
      if (addr2_valid && rdy[2]) q2.push_back(addr2_data);
    end
  end

  function automatic int obs_size(int p);
    case (p)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [AW-1:0] obs_at(int p, int i);
    case (p)
      0:       return q0[i];
      1:       return q1[i];
      default: return q2[i];
    endcase
  endfunction

  task automatic clear_streams();
    q0.delete();
    q1.delete();
    q2.delete();
    exp_q.delete();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stage_valid = 1'b0;
    stage_start = '0;
    stage_len = '0;
    rdy = 3'b000;
    repeat (3) begin
      cyc();
      #1;
      checks++;
      if ({stage_ready, busy, vld} !== 5'b0 || dat !== '0 || lst !== 3'b0) begin
        errors++;
        $display("FAIL reset_outputs got rdy=%b busy=%b vld=%b dat=%h want all zero",
                 stage_ready, busy, vld, dat);
      end
    end
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if ({stage_ready, busy, vld} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_release got rdy=%b busy=%b vld=%b want rdy=1 busy=0 vld=000",
               stage_ready, busy, vld);
    end
  endtask

  task automatic test_basic();
    logic [AW-1:0] a;
    rdy = 3'b111;
    cyc();
    stage_valid = 1'b1;
    stage_start = 12'h010;
    stage_len = 8'd4;
    #1;
    checks++;
    if (stage_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept got stage_ready=%b want 1", stage_ready);
    end
    cyc();
    stage_valid = 1'b0;
    stage_start = 12'hABC;
    stage_len = 8'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      a = 12'h010 + 12'(i);
      checks++;
      if (vld !== 3'b111 || dat !== {3{a}} || busy !== 1'b1 || stage_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_beat%0d got vld=%b dat=%h busy=%b want vld=111 addr=%h busy=1",
                 i, vld, dat, busy, a);
      end
`ifdef FEATURE_ADDR_LAST_EN
      checks++;
      if (lst !== ((i == 3) ? 3'b111 : 3'b000)) begin
        errors++;
        $display("FAIL basic_last%0d got %b want %b", i, lst, (i == 3) ? 3'b111 : 3'b000);
      end
`endif
      cyc();
    end
    #1;
    checks++;
    if ({stage_ready, busy, vld} !== 5'b10000) begin
      errors++;
      $display("FAIL basic_done got rdy=%b busy=%b vld=%b want rdy=1 busy=0 vld=000",
               stage_ready, busy, vld);
    end
  endtask

  task automatic test_skew();
    clear_streams();
    exp_q.push_back(12'h100);
    exp_q.push_back(12'h101);
    rdy = 3'b111;
    cyc();
    stage_valid = 1'b1;
    stage_start = 12'h100;
    stage_len = 8'd2;
    cyc();
    stage_valid = 1'b0;
    rdy = 3'b101;
    #1;
    checks++;
    if (vld !== 3'b111 || dat !== {3{12'h100}}) begin
      errors++;
      $display("FAIL skew_first got vld=%b dat=%h want 111 addr 100", vld, dat);
    end
    for (int c = 0; c < 2; c++) begin
      cyc();
      #1;
      checks++;
      if (vld !== 3'b010 || addr1_data !== 12'h100) begin
        errors++;
        $display("FAIL skew_hold%0d got vld=%b d1=%h want vld=010 d1=100", c, vld, addr1_data);
      end
    end
    cyc();
    rdy = 3'b111;
    #1;
    checks++;
    if (vld !== 3'b010 || addr1_data !== 12'h100) begin
      errors++;
      $display("FAIL skew_release got vld=%b d1=%h want vld=010 d1=100", vld, addr1_data);
    end
    cyc();
    #1;
    checks++;
    if (vld !== 3'b111 || dat !== {3{12'h101}}) begin
      errors++;
      $display("FAIL skew_second got vld=%b dat=%h want 111 addr 101", vld, dat);
    end
    cyc();
    #1;
    checks++;
    if ({stage_ready, vld} !== 4'b1000) begin
      errors++;
      $display("FAIL skew_done got rdy=%b vld=%b want rdy=1 vld=000", stage_ready, vld);
    end
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (obs_size(p) !== exp_q.size()) begin
        errors++;
        $display("FAIL skew_count_p%0d got %0d want %0d", p, obs_size(p), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (obs_at(p, i) !== exp_q[i]) begin
            errors++;
            $display("FAIL skew_stream_p%0d[%0d] got %h want %h", p, i, obs_at(p, i), exp_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_wrap_zero();
    logic [AW-1:0] a;
    rdy = 3'b111;
    cyc();
    stage_valid = 1'b1;
    stage_start = 12'hFFE;
    stage_len = 8'd3;
    cyc();
    stage_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      a = 12'hFFE + 12'(i);
      checks++;
      if (vld !== 3'b111 || dat !== {3{a}}) begin
        errors++;
        $display("FAIL wrap_beat%0d got vld=%b dat=%h want 111 addr %h", i, vld, dat, a);
      end
      cyc();
    end
    stage_valid = 1'b1;
    stage_start = 12'h123;
    stage_len = 8'd0;
    #1;
    checks++;
    if (stage_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_accept got stage_ready=%b want 1", stage_ready);
    end
    for (int c = 0; c < 3; c++) begin
      cyc();
      stage_valid = 1'b0;
      #1;
      checks++;
      if ({stage_ready, busy, vld} !== 5'b10000) begin
        errors++;
        $display("FAIL zero_idle%0d got rdy=%b busy=%b vld=%b want rdy=1 busy=0 vld=000",
                 c, stage_ready, busy, vld);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_streams();
    for (int i = 0; i < 4; i++) exp_q.push_back(12'h020 + 12'(i));
    exp_q.push_back(12'h050);
    rdy = 3'b111;
    cyc();
    stage_valid = 1'b1;
    stage_start = 12'h020;
    stage_len = 8'd10;
    cyc();
    stage_valid = 1'b0;
    repeat (4) cyc();
    rst = 1'b1;
    #1;
    checks++;
    if ({stage_ready, busy, vld} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_during got rdy=%b busy=%b vld=%b want all zero",
               stage_ready, busy, vld);
    end
    cyc();
    #1;
    checks++;
    if (vld !== 3'b000 || dat !== '0) begin
      errors++;
      $display("FAIL midrst_hold got vld=%b dat=%h want 000 and zero", vld, dat);
    end
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if ({stage_ready, busy, vld} !== 5'b10000) begin
      errors++;
      $display("FAIL midrst_release got rdy=%b busy=%b vld=%b want rdy=1 busy=0 vld=000",
               stage_ready, busy, vld);
    end
    stage_valid = 1'b1;
    stage_start = 12'h050;
    stage_len = 8'd1;
    cyc();
    stage_valid = 1'b0;
    #1;
    checks++;
    if (vld !== 3'b111 || dat !== {3{12'h050}}) begin
      errors++;
      $display("FAIL midrst_new got vld=%b dat=%h want 111 addr 050", vld, dat);
    end
`ifdef FEATURE_ADDR_LAST_EN
    checks++;
    if (lst !== 3'b111) begin
      errors++;
      $display("FAIL midrst_last got %b want 111", lst);
    end
`endif
    cyc();
    #1;
    checks++;
    if ({stage_ready, vld} !== 4'b1000) begin
      errors++;
      $display("FAIL midrst_done got rdy=%b vld=%b want rdy=1 vld=000", stage_ready, vld);
    end
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (obs_size(p) !== exp_q.size()) begin
        errors++;
        $display("FAIL midrst_count_p%0d got %0d want %0d", p, obs_size(p), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (obs_at(p, i) !== exp_q[i]) begin
            errors++;
            $display("FAIL midrst_stream_p%0d[%0d] got %h want %h", p, i, obs_at(p, i),
                     exp_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int  ndesc = 0;
    int  ncyc = 0;
    bit  need_new = 1'b1;
    bit  done = 1'b0;
    clear_streams();
    stage_valid = 1'b0;
    while (!done && ncyc < 20000) begin
      cyc();
      ncyc++;
      rdy[0] = ($urandom_range(0, 3) != 0);
      rdy[1] = ($urandom_range(0, 3) != 0);
      rdy[2] = ($urandom_range(0, 3) != 0);
      if (need_new) begin
        if (ndesc < 200) begin
          stage_start = 12'($urandom);
          stage_len = 8'($urandom_range(0, 5));
          stage_valid = 1'b1;
          need_new = 1'b0;
        end else begin
          stage_valid = 1'b0;
        end
      end
      #1;
      if (stage_valid && stage_ready) begin
        for (int i = 0; i < int'(stage_len); i++) exp_q.push_back(stage_start + 12'(i));
        ndesc++;
        need_new = 1'b1;
      end else if (!stage_valid && stage_ready && ndesc == 200) begin
        done = 1'b1;
      end
    end
    rdy = 3'b000;
    stage_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL random_timeout got %0d descriptors want 200", ndesc);
    end
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (obs_size(p) !== exp_q.size()) begin
        errors++;
        $display("FAIL random_count_p%0d got %0d want %0d", p, obs_size(p), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (obs_at(p, i) !== exp_q[i]) begin
            errors++;
            $display("FAIL random_stream_p%0d[%0d] got %h want %h", p, i, obs_at(p, i),
                     exp_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    stage_valid = 1'b0;
    stage_start = '0;
    stage_len = '0;
    rdy = 3'b000;
    test_reset();
    test_basic();
    test_skew();
    test_wrap_zero();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/feature_addr_gen.md
Name: feature_addr_gen

Overview:
- Upstream address sequencer for the weight ROM read stages (weights 0/1/2) of the cascade classifier.
- Accepts one stage descriptor (start address, feature count) per transaction.
- Emits consecutive feature addresses start..start+len-1 and broadcasts each address to three independent valid/ready address ports, one per weight ROM reader.
- Uses an eager fork: each port may complete its handshake in a different cycle. The next address issues only after all three ports have taken the current one.

Parameters:
- W_ADDR, 12, width of the ROM address / feature index.
- W_LEN, 8, width of the feature-count field (max count 2^W_LEN-1).
- N_OUT, 3, number of address output ports (fixed at 3; other values are not supported).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stage_valid  input  1  stage descriptor valid.
- stage_ready  output  1  descriptor accepted when valid & ready.
- stage_start  input  W_ADDR  first feature address.
- stage_len  input  W_LEN  number of addresses to issue.
- addr0_valid  output  1  address valid toward weight ROM 0 reader.
- addr0_ready  input  1  ROM 0 reader accepts.
- addr0_data  output  W_ADDR  address for ROM 0.
- addr1_valid / addr1_ready / addr1_data: same as port 0, toward ROM 1 reader.
- addr2_valid / addr2_ready / addr2_data: same as port 0, toward ROM 2 reader.
- busy  output  1  high while in RUN.

Behaviour:
- Reset
  - rst is synchronous, active-high.
  - While rst is asserted and on the first cycle after: state=IDLE, cur=0, remaining=0, sent[2:0]=0.
  - During rst: all addrN_valid=0, stage_ready=0, busy=0, addrN_data=0.
  - rst mid-RUN aborts the sequence immediately; no further addresses are issued.
- States
  - IDLE:
    - stage_ready=1 (combinational from state, gated by ~rst); all addrN_valid=0.
    - On stage handshake with stage_len!=0: cur<=stage_start, remaining<=stage_len, sent<=0, go to RUN.
    - On stage handshake with stage_len==0: descriptor is consumed, no addresses are issued, remain in IDLE.
  - RUN:
    - stage_ready=0 (no descriptor overlap). busy=1.
    - addrN_data=cur for all N.
    - addrN_valid = ~sent[N]. Once asserted, it holds until handshake and cur does not change while any valid is pending.
    - Handshake on port N (valid & ready) sets sent[N] next cycle.
    - Beat completion when, for every N, sent[N] | (addrN_valid & addrN_ready) holds this cycle. On completion:
      - sent<=0.
      - cur<=cur+1, modulo 2^W_ADDR; wrap from all-ones to 0 is legal.
      - remaining<=remaining-1.
      - If remaining==1: go to IDLE.
- Throughput and latency
  - Full throughput: 1 address per cycle when all readies are high.
  - First address is valid the cycle after the descriptor handshake.
  - One idle bubble between stages: stage_ready rises the cycle after the last beat completes.
- Independence of ports
  - A port that has already handshaken the current address deasserts its valid and ignores its ready until the beat completes.
  - A port that keeps ready low stalls the whole sequence; the other ports never advance more than one address ahead.
- stage_start and stage_len are sampled only at the handshake; later changes have no effect.

Optional Feature:
- Macro: FEATURE_ADDR_LAST_EN.
- Defined:
  - Adds outputs addr0_last, addr1_last, addr2_last (1 bit each).
  - addrN_last=1 exactly when addrN_valid=1 and remaining==1, i.e. on the final address of the stage.
  - addrN_last is 0 otherwise and during reset.
  - Downstream stages use it to frame the stage sum.
- Undefined: the last ports do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: hold rst 3 cycles, release.
  - Required: stage_ready=1 and all addrN_valid=0 from the first cycle after release; busy=0.
- Basic stage, all readies high: start=0x010, len=4.
  - Required: addresses 0x010, 0x011, 0x012, 0x013 on all three ports in 4 consecutive cycles, first on the cycle after the handshake.
  - Required: stage_ready=1 again on the cycle after 0x013 is taken; with FEATURE_ADDR_LAST_EN, last=1 only on 0x013.
- Skewed ports: start=0x100, len=2; addr1_ready low for 3 cycles, others high.
  - Required: addr0 and addr2 take 0x100 once, then deassert valid.
  - Required: 0x101 appears on all ports only after addr1 accepts 0x100.
  - Required: no duplicate or skipped addresses on any port.
- Wrap and zero length:
  - start=0xFFE, len=3: required sequence 0xFFE, 0xFFF, 0x000.
  - Then len=0 descriptor: accepted in 1 cycle, no addrN_valid pulse, state stays IDLE.
- Reset mid-run: start=0x020, len=10; assert rst after 4 addresses complete.
  - Required: all valids low during rst.
  - Required: after release, IDLE with stage_ready=1.
  - Required: a new descriptor start=0x050, len=1 issues only 0x050.
- Random backpressure: 200 random descriptors with random per-port ready.
  - Required: each port's observed address stream equals the concatenation of start..start+len-1 per descriptor, in order.
